// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for pipeline segment registers
// Contents:
//   seg_state_e      occupancy of a segment: EMPTY, FULL (out only), SKID (out + skid)
//   DEFAULT_WIDTH    default payload width of a segment
//   FLUSH_NOP        flush value for instruction fields (addi x0,x0,0)
//   FLUSH_DATA       flush value for data fields
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } seg_state_e;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [31:0] FLUSH_NOP  = 32'h0000_0013;
    localparam logic [31:0] FLUSH_DATA = 32'h0000_0000;

endpackage

// File: rtl/pipe_seg_reg.sv
// rtl/pipe_seg_reg.sv - pipeline segment register with valid/ready handshake and one-entry skid
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   bubble     hold request; freezes every register including stall_cnt
//   flush      clear request; empties the segment, out_data <= FLUSH_VAL
//   in_valid   upstream payload valid
//   in_data    upstream payload
//   in_ready   registered, high unless the skid entry is occupied
//   out_valid  out_data holds a live payload
//   out_data   payload to the next stage
//   out_ready  downstream accepts out_data this cycle
//   stall_cnt  saturating count of cycles with out_valid=1 and no transfer out
module pipe_seg_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bubble,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    seg_state_e       state;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    logic accept_in;
    logic accept_out;

    assign accept_in  = in_valid  & in_ready  & ~bubble;
    assign accept_out = out_valid & out_ready & ~bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EMPTY;
            out_valid  <= 1'b0;
            out_data   <= FLUSH_VAL;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b1;
            stall_cnt  <= '0;
        end else if (!bubble) begin
            // A flush cycle is not counted as a stall: the payload is being discarded.
            if (out_valid && !out_ready && !flush && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_ONE;

            if (flush) begin
                // Same-cycle in_data is dropped; a same-cycle transfer out already
                // happened from downstream's point of view, so nothing to undo.
                state      <= ST_EMPTY;
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
                out_data   <= FLUSH_VAL;
                in_ready   <= 1'b1;
            end else begin
                case (state)
                    ST_EMPTY: begin
                        if (accept_in) begin
                            out_data  <= in_data;
                            out_valid <= 1'b1;
                            state     <= ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        if (accept_in && accept_out) begin
                            out_data <= in_data;
                        end else if (accept_in) begin
                            // Downstream stalled while upstream still pushed: park it.
                            skid_data  <= in_data;
                            skid_valid <= 1'b1;
                            in_ready   <= 1'b0;
                            state      <= ST_SKID;
                        end else if (accept_out) begin
                            // out_data keeps its last value when the segment drains.
                            out_valid <= 1'b0;
                            state     <= ST_EMPTY;
                        end
                    end
                    ST_SKID: begin
                        if (accept_out) begin
                            out_data   <= skid_data;
                            skid_valid <= 1'b0;
                            in_ready   <= 1'b1;
                            state      <= ST_FULL;
                        end
                    end
                    default: begin
                        state      <= ST_EMPTY;
                        out_valid  <= 1'b0;
                        skid_valid <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_seg_reg.sv
// tb/tb_pipe_seg_reg.sv - self-checking bench for pipe_seg_reg
module tb_pipe_seg_reg;

    localparam int          W    = 32;
    localparam logic [31:0] FVAL = 32'h13;

    logic          clk = 1'b0;
    logic          rst, bubble, flush, in_valid, out_ready;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid;
    logic [W-1:0]  out_data;
    logic [15:0]   stall_cnt;
    logic          in_ready4, out_valid4;
    logic [W-1:0]  out_data4;
    logic [3:0]    stall_cnt4;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: payloads held by the segment, head = current out_data.
    logic [W-1:0] q[$];
    logic [W-1:0] exp_data;
    int           exp_stall;
    int           exp_stall4;

    always #5 clk = ~clk;

    pipe_seg_reg #(.WIDTH(W), .FLUSH_VAL(FVAL), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bubble(bubble), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .stall_cnt(stall_cnt)
    );

    pipe_seg_reg #(.WIDTH(W), .FLUSH_VAL(FVAL), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bubble(bubble), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready),
        .stall_cnt(stall_cnt4)
    );

    // Advance one clock, updating the reference model from the inputs in force.
    task automatic tick();
        bit acc_out, acc_in;
        if (rst) begin
            q.delete();
            exp_data   = FVAL;
            exp_stall  = 0;
            exp_stall4 = 0;
        end else if (!bubble) begin
            if (q.size() > 0 && !out_ready && !flush) begin
                if (exp_stall  < 65535) exp_stall++;
                if (exp_stall4 < 15)    exp_stall4++;
            end
            acc_out = (q.size() > 0) && out_ready;
            acc_in  = in_valid && (q.size() < 2);
            if (flush) begin
                q.delete();
                exp_data = FVAL;
            end else begin
                if (acc_out) void'(q.pop_front());
                if (acc_in)  q.push_back(in_data);
                if (q.size() > 0) exp_data = q[0];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bubble = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0)   begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== FVAL)    begin failures++; $display("FAIL reset_out_data got=%h exp=%h", out_data, FVAL); end
        checks++; if (in_ready !== 1'b1)    begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (stall_cnt !== 16'd0)  begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (stall_cnt4 !== 4'd0)  begin failures++; $display("FAIL reset_stall_cnt4 got=%0d exp=0", stall_cnt4); end
    endtask

    task automatic test_stream();
        int seen = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 5);
            in_data  = i + 1;
            checks++; if (out_valid !== (q.size() > 0)) begin failures++; $display("FAIL stream_valid cyc=%0d got=%0b exp=%0b", i, out_valid, q.size() > 0); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready cyc=%0d got=%0b exp=1", i, in_ready); end
            if (q.size() > 0) begin
                seen++;
                checks++; if (out_data !== q[0] || out_data !== W'(i)) begin failures++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", i, out_data, q[0]); end
            end
            tick();
        end
        checks++; if (seen != 5) begin failures++; $display("FAIL stream_count got=%0d exp=5", seen); end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] order[$];
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hAAAA_0001; tick();
        in_data = 32'hBBBB_0002; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
            checks++; if (stall_cnt !== 16'(exp_stall) || exp_stall != i + 1) begin failures++; $display("FAIL bp_stall got=%0d exp=%0d", stall_cnt, i + 1); end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL bp_drain_in_ready cyc=%0d got=%0b exp=%0b", i, in_ready, q.size() < 2); end
            if (out_valid) order.push_back(out_data);
            checks++; if (out_valid !== (q.size() > 0)) begin failures++; $display("FAIL bp_drain_valid cyc=%0d got=%0b exp=%0b", i, out_valid, q.size() > 0); end
            tick();
        end
        checks++; if (order.size() != 2 || order[0] !== 32'hAAAA_0001 || order[1] !== 32'hBBBB_0002) begin
            failures++; $display("FAIL bp_order got_n=%0d exp=AAAA0001,BBBB0002", order.size());
        end
    endtask

    task automatic test_bubble_flush();
        logic [15:0] held_stall;
        do_reset();
        in_valid = 1'b1; in_data = 32'h1111; tick();
        in_data = 32'h2222; tick();
        held_stall = 16'(exp_stall);
        bubble = 1'b1; flush = 1'b1; out_ready = 1'b1; in_data = 32'h3333;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 32'h1111) begin
                failures++; $display("FAIL bubble_hold cyc=%0d valid=%0b ready=%0b data=%h exp 1/0/00001111", i, out_valid, in_ready, out_data);
            end
            checks++; if (stall_cnt !== held_stall) begin failures++; $display("FAIL bubble_stall got=%0d exp=%0d", stall_cnt, held_stall); end
        end
        bubble = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        tick();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== FVAL || in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_after_bubble valid=%0b data=%h ready=%0b exp 0/%h/1", out_valid, out_data, in_ready, FVAL);
        end
        checks++; if (stall_cnt !== held_stall) begin failures++; $display("FAIL flush_stall got=%0d exp=%0d", stall_cnt, held_stall); end
    endtask

    task automatic test_flush_drop();
        do_reset();
        in_valid = 1'b1; in_data = 32'h0000_00AB; tick();
        flush = 1'b1; in_data = 32'h0000_DEAD; tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0 || out_data !== FVAL) begin
            failures++; $display("FAIL flush_drop valid=%0b data=%h exp 0/%h", out_valid, out_data, FVAL);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_data === 32'h0000_DEAD) begin
                failures++; $display("FAIL flush_dead cyc=%0d valid=%0b data=%h", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        in_valid = 1'b1; in_data = 32'h55; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (stall_cnt4 !== 4'd15 || exp_stall4 != 15) begin failures++; $display("FAIL sat_cnt4 got=%0d exp=15", stall_cnt4); end
        checks++; if (stall_cnt !== 16'(exp_stall) || exp_stall != 20) begin failures++; $display("FAIL sat_cnt16 got=%0d exp=20", stall_cnt); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (stall_cnt4 !== 4'd0) begin failures++; $display("FAIL sat_rst got=%0d exp=0", stall_cnt4); end
    endtask

    task automatic test_random();
        int sent = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            bubble    = ($urandom_range(0, 9) == 0);
            in_data   = 32'h1000 + sent;
            if (in_valid && q.size() < 2 && !bubble) sent++;
            checks++; if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                failures++; $display("FAIL rand_flags cyc=%0d valid=%0b ready=%0b exp_n=%0d", i, out_valid, in_ready, q.size());
            end
            if (q.size() > 0) begin
                checks++; if (out_data !== q[0]) begin failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, out_data, q[0]); end
            end
            checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL rand_stall cyc=%0d got=%0d exp=%0d", i, stall_cnt, exp_stall); end
            tick();
        end
        bubble = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        exp_data = FVAL; exp_stall = 0; exp_stall4 = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble_flush();
        test_flush_drop();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
